sprite_hpos_emit: RTL and testbench
===================================

Name: sprite_hpos_emit

Overview:
- Downstream of the fast-cycle VRAM stage. Consumes the delayed sprite attribute word (x position, h-shrink, chain bit) on the pipe-C bus.
- Turns each sprite into 16 pixel slots of line-buffer write address/enable, with h-shrink pixel dropping and chained-sprite x accumulation.
- Has a one-entry pending buffer so back-to-back sprites emit with no bubble.

Parameters:
- X_W, 9, line-buffer address / x-position width; arithmetic is mod 2^X_W.
- VIS_WIDTH, 320, first off-screen x; used only when LB_CLIP_EN is defined.

Ports:
- CLK_24M  in  1  master clock; all logic on rising edge.
- nRESET  in  1  reset, asynchronous, active-low.
- LINE_START  in  1  single-cycle pulse at the start of each line's sprite render.
- SPR_LOAD  in  1  single-cycle pulse: PIPE_C holds a valid sprite attribute this cycle.
- PIPE_C  in  16  attribute word: [8:0] x position, [12:9] h-shrink, [13] chain, [15:14] ignored.
- LB_ADDR  out  X_W  line-buffer write address for the current slot.
- LB_WE  out  1  line-buffer write enable for the current slot.
- PIX_IDX  out  4  source pixel column (0..15) of the current slot, for the graphics fetch.
- BUSY  out  1  emitting, or pending entry valid.
- SPR_DONE  out  1  one-cycle pulse in the cycle after slot 15 of a sprite.
- OVERRUN  out  1  sticky: a load was dropped; cleared by LINE_START.

Behaviour:
- Reset (nRESET low, async): LB_ADDR=0, LB_WE=0, PIX_IDX=0, BUSY=0, SPR_DONE=0, OVERRUN=0. Also NEXT_X=0, pending invalid, state IDLE, slot counter 0.
- Shrink mask:
  - Source pixel i (0..15) is kept for shrink h iff floor((i+1)*(h+1)/16) != floor(i*(h+1)/16).
  - Exactly h+1 pixels are kept. h=15 keeps all; h=0 keeps only i=15; h=7 keeps odd i.
- Accept (SPR_LOAD=1, LINE_START=0), evaluated at the clock edge:
  - X_eff = chain ? NEXT_X : PIPE_C[8:0].
  - Register NEXT_X <= X_eff + h + 1 (mod 2^X_W).
  - Capture {X_eff, h} into the active set if state is IDLE.
  - Otherwise capture into pending if pending is empty.
  - Otherwise drop the load and set OVERRUN; NEXT_X is not updated on a drop.
- State machine:
  - IDLE -> EMIT on accept.
  - EMIT runs slots 0..15, one per cycle, slot k visible on the outputs k+1 cycles after the accept edge.
  - At slot 15: if pending is valid, pending moves to active and slot 0 of that sprite follows immediately, with no bubble. Otherwise go to IDLE.
- Per slot:
  - PIX_IDX = slot.
  - LB_WE = mask[h][slot].
  - LB_ADDR = X_eff + number of kept pixels before this slot (mod 2^X_W).
  - On dropped slots LB_WE=0 and LB_ADDR holds the next write address.
- SPR_DONE pulses for one cycle after the last slot of each sprite. It coincides with slot 0 of a following pending sprite.
- Wrap-around: addresses wrap 511 -> 0 (X_W=9); no flag is raised.
- LINE_START (synchronous, highest priority):
  - Clears NEXT_X, pending and OVERRUN; forces IDLE; LB_WE=0 on the next cycle.
  - Aborts any emission without pulsing SPR_DONE.
  - A SPR_LOAD in the same cycle is dropped without setting OVERRUN.
- nRESET asserted mid-emission: all state clears immediately; LB_WE drops asynchronously.

Optional Feature:
- LB_CLIP_EN defined: LB_WE is forced 0 for any slot whose LB_ADDR >= VIS_WIDTH. The kept-pixel count still advances, so addresses are unchanged.
- Undefined: no clipping; every kept slot writes.

Decomposition:
- Shared package sprite_pkg holds:
  - SPR_SLOTS=16 and the field offsets of the pipe-C word (X lsb 0, HSHRINK lsb 9, CHAIN bit 13).
  - A 16x16-bit constant table HSHRINK_MASK generated by the mask rule above.
  - State enum {ST_IDLE, ST_EMIT}.
- One sub-module: sprite_hpos_slot. Holds the slot counter and the kept-pixel accumulator, and produces LB_ADDR/LB_WE/PIX_IDX for one active sprite. The parent owns accept, pending, NEXT_X and OVERRUN.

Test Plan:
- Basic: load X=10, h=15, chain=0 -> 16 cycles LB_WE=1, LB_ADDR 10..25, PIX_IDX 0..15; SPR_DONE next cycle; NEXT_X=26.
- Chain: then load chain=1, h=7 (X field=200, ignored) -> LB_WE only at PIX_IDX 1,3,...,15, LB_ADDR 26..33; NEXT_X=34.
- Back-to-back and overrun:
  - Three loads on consecutive cycles (h=15 each) -> 2nd starts at the cycle after slot 15 of the 1st, no bubble.
  - 3rd dropped, OVERRUN=1 until LINE_START.
- Wrap: load X=508, h=15 -> LB_ADDR 508,509,510,511,0..11.
- Clip: load X=312, h=15 -> with LB_CLIP_EN only 8 writes (312..319); without it 16 writes up to 327.
- Abort:
  - LINE_START at slot 5 with pending valid -> LB_WE=0 next cycle, BUSY=0, no SPR_DONE.
  - Next chained load starts at X=0.
  - nRESET pulse mid-emission clears all outputs asynchronously.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite horizontal emitter: pipe-C field layout,
// FSM state type and the 16x16 h-shrink keep-mask table.
package sprite_pkg;

   localparam int SPR_SLOTS   = 16;
   localparam int X_LSB       = 0;
   localparam int HSHRINK_LSB = 9;
   localparam int HSHRINK_W   = 4;
   localparam int CHAIN_BIT   = 13;

   typedef enum logic {ST_IDLE, ST_EMIT} st_e;

   typedef logic [SPR_SLOTS-1:0][SPR_SLOTS-1:0] mask_tbl_t;

   // Pixel i survives shrink h when the scaled pixel boundary advances across it,
   // which spreads exactly h+1 kept pixels evenly over the 16 source columns.
   function automatic mask_tbl_t gen_hshrink_mask();
      mask_tbl_t t;
      t = '0;
      for (int h = 0; h < SPR_SLOTS; h++) begin
         for (int i = 0; i < SPR_SLOTS; i++) begin
            t[h][i] = (((i + 1) * (h + 1)) / SPR_SLOTS) != ((i * (h + 1)) / SPR_SLOTS);
         end
      end
      return t;
   endfunction

   localparam mask_tbl_t HSHRINK_MASK = gen_hshrink_mask();

   function automatic logic slot_kept(input logic [3:0] h, input logic [3:0] slot);
      return HSHRINK_MASK[h][slot];
   endfunction

endpackage

// File: rtl/sprite_hpos_slot.sv
// Slot sequencer for one active sprite: walks source columns 0..15 and emits the
// registered line-buffer address/enable/column. Clipping is built in when LB_CLIP_EN is defined.
module sprite_hpos_slot
   import sprite_pkg::*;
#(
   parameter int X_W       = 9,
   parameter int VIS_WIDTH = 320
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_clr,
   input  logic           i_run,
   input  logic           i_start,
   input  logic [X_W-1:0] i_x,
   input  logic [3:0]     i_h,
   output logic [X_W-1:0] o_lb_addr,
   output logic           o_lb_we,
   output logic [3:0]     o_pix_idx,
   output logic           o_vld,
   output logic           o_last
);

`ifdef LB_CLIP_EN
   localparam logic CLIP_ON = 1'b1;
`else
   localparam logic CLIP_ON = 1'b0;
`endif

   logic [X_W-1:0] r_x;
   logic [3:0]     r_h;
   logic [3:0]     r_slot;
   logic [4:0]     r_kept;

   logic           w_keep;
   logic [X_W-1:0] w_addr;
   logic           w_visible;

   assign w_keep    = slot_kept(r_h, r_slot);
   assign w_addr    = r_x + X_W'(r_kept);
   assign w_visible = !CLIP_ON || (32'(w_addr) < 32'(VIS_WIDTH));
   assign o_last    = i_run && (r_slot == 4'd15);

   // Start wins over increment so a back-to-back sprite reloads on the slot-15 edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x    <= '0;
         r_h    <= '0;
         r_slot <= '0;
         r_kept <= '0;
      end else if (i_clr) begin
         r_slot <= '0;
         r_kept <= '0;
      end else if (i_start) begin
         r_x    <= i_x;
         r_h    <= i_h;
         r_slot <= '0;
         r_kept <= '0;
      end else if (i_run) begin
         r_slot <= r_slot + 4'd1;
         r_kept <= r_kept + {4'b0, w_keep};
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_lb_addr <= '0;
         o_lb_we   <= 1'b0;
         o_pix_idx <= '0;
         o_vld     <= 1'b0;
      end else if (i_clr) begin
         o_lb_we <= 1'b0;
         o_vld   <= 1'b0;
      end else if (i_run) begin
         o_lb_addr <= w_addr;
         o_lb_we   <= w_keep && w_visible;
         o_pix_idx <= r_slot;
         o_vld     <= 1'b1;
      end else begin
         o_lb_we <= 1'b0;
         o_vld   <= 1'b0;
      end
   end

endmodule

// File: rtl/sprite_hpos_emit.sv
// Sprite horizontal emitter: accepts pipe-C attributes, tracks chained x, holds one
// pending sprite and drives the slot sequencer. Optional clipping macro: LB_CLIP_EN.
module sprite_hpos_emit
   import sprite_pkg::*;
#(
   parameter int X_W       = 9,
   parameter int VIS_WIDTH = 320
) (
   input  logic           CLK_24M,
   input  logic           nRESET,
   input  logic           LINE_START,
   input  logic           SPR_LOAD,
   input  logic [15:0]    PIPE_C,
   output logic [X_W-1:0] LB_ADDR,
   output logic           LB_WE,
   output logic [3:0]     PIX_IDX,
   output logic           BUSY,
   output logic           SPR_DONE,
   output logic           OVERRUN,
   output st_e            o_dbg_state
);

   // SPR_LOAD is a valid-only pulse with no ready: a load is consumed on the edge it
   // is high (into active or pending), otherwise it is dropped and OVERRUN records it.

   st_e            r_state;
   logic [X_W-1:0] r_next_x;
   logic           r_pend_vld;
   logic [X_W-1:0] r_pend_x;
   logic [3:0]     r_pend_h;

   logic [3:0]     w_h;
   logic           w_chain;
   logic [X_W-1:0] w_x_eff;
   logic [X_W-1:0] w_next_sum;
   logic           w_load;
   logic           w_slot_last;
   logic           w_out_vld;
   logic           w_to_active;
   logic           w_to_pend;
   logic           w_drop;
   logic           w_pend_pop;
   logic           w_start;
   logic [X_W-1:0] w_start_x;
   logic [3:0]     w_start_h;
   logic           w_unused_bits;

   assign w_h           = PIPE_C[HSHRINK_LSB +: HSHRINK_W];
   assign w_chain       = PIPE_C[CHAIN_BIT];
   assign w_x_eff       = w_chain ? r_next_x : PIPE_C[X_LSB +: X_W];
   assign w_next_sum    = w_x_eff + X_W'(w_h) + X_W'(1);
   assign w_load        = SPR_LOAD && !LINE_START;
   assign w_unused_bits = &{1'b0, PIPE_C[15:14]};

   // A load landing on the slot-15 edge with nothing pending goes straight to active
   // so it is not stranded in pending while the FSM falls back to idle.
   assign w_to_active = w_load && ((r_state == ST_IDLE) ||
                                   (r_state == ST_EMIT && w_slot_last && !r_pend_vld));
   assign w_to_pend   = w_load && !w_to_active && !r_pend_vld;
   assign w_drop      = w_load && !w_to_active && r_pend_vld;
   assign w_pend_pop  = !LINE_START && (r_state == ST_EMIT) && w_slot_last && r_pend_vld;
   assign w_start     = w_to_active || w_pend_pop;
   assign w_start_x   = w_pend_pop ? r_pend_x : w_x_eff;
   assign w_start_h   = w_pend_pop ? r_pend_h : w_h;

   assign BUSY        = (r_state == ST_EMIT) || r_pend_vld || w_out_vld;
   assign o_dbg_state = r_state;

   always_ff @(posedge CLK_24M or negedge nRESET) begin
      if (!nRESET) begin
         r_state    <= ST_IDLE;
         r_next_x   <= '0;
         r_pend_vld <= 1'b0;
         r_pend_x   <= '0;
         r_pend_h   <= '0;
         OVERRUN    <= 1'b0;
         SPR_DONE   <= 1'b0;
      end else if (LINE_START) begin
         r_state    <= ST_IDLE;
         r_next_x   <= '0;
         r_pend_vld <= 1'b0;
         OVERRUN    <= 1'b0;
         SPR_DONE   <= 1'b0;
      end else begin
         SPR_DONE <= w_out_vld && (PIX_IDX == 4'd15);
         if (w_to_active || w_to_pend) begin
            r_next_x <= w_next_sum;
         end
         if (w_to_pend) begin
            r_pend_vld <= 1'b1;
            r_pend_x   <= w_x_eff;
            r_pend_h   <= w_h;
         end else if (w_pend_pop) begin
            r_pend_vld <= 1'b0;
         end
         if (w_drop) begin
            OVERRUN <= 1'b1;
         end
         case (r_state)
            ST_IDLE: if (w_to_active) r_state <= ST_EMIT;
            ST_EMIT: if (w_slot_last && !w_start) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   sprite_hpos_slot #(
      .X_W       (X_W),
      .VIS_WIDTH (VIS_WIDTH)
   ) u_slot (
      .i_clk     (CLK_24M),
      .i_rst_n   (nRESET),
      .i_clr     (LINE_START),
      .i_run     (r_state == ST_EMIT),
      .i_start   (w_start),
      .i_x       (w_start_x),
      .i_h       (w_start_h),
      .o_lb_addr (LB_ADDR),
      .o_lb_we   (LB_WE),
      .o_pix_idx (PIX_IDX),
      .o_vld     (w_out_vld),
      .o_last    (w_slot_last)
   );

endmodule

// File: tb/tb_sprite_hpos_emit.sv
// Directed bench for sprite_hpos_emit: basic, chain, back-to-back/overrun, wrap,
// clip, LINE_START abort and asynchronous reset.
module tb_sprite_hpos_emit;

   logic       clk;
   logic       rst_n;
   logic       line_start;
   logic       spr_load;
   logic [15:0] pipe_c;
   logic [8:0] lb_addr;
   logic       lb_we;
   logic [3:0] pix_idx;
   logic       busy;
   logic       spr_done;
   logic       overrun;
   sprite_pkg::st_e dbg_state;

   int n_vec;
   int n_err;
   int wr_cnt;
   logic [8:0] wr_max;

   sprite_hpos_emit #(.X_W(9), .VIS_WIDTH(320)) dut (
      .CLK_24M     (clk),
      .nRESET      (rst_n),
      .LINE_START  (line_start),
      .SPR_LOAD    (spr_load),
      .PIPE_C      (pipe_c),
      .LB_ADDR     (lb_addr),
      .LB_WE       (lb_we),
      .PIX_IDX     (pix_idx),
      .BUSY        (busy),
      .SPR_DONE    (spr_done),
      .OVERRUN     (overrun),
      .o_dbg_state (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic kept(input int h, input int i);
      return (((i + 1) * (h + 1)) / 16) != ((i * (h + 1)) / 16);
   endfunction

   // driver: present one attribute for a single accept edge
   task automatic set_load(input logic [8:0] x, input logic [3:0] h, input logic chain);
      spr_load = 1'b1;
      pipe_c   = {2'b00, chain, h, x};
   endtask

   task automatic load(input logic [8:0] x, input logic [3:0] h, input logic chain);
      set_load(x, h, chain);
      step();
      spr_load = 1'b0;
   endtask

   // advance one cycle and check slot k of a sprite at x with shrink h
   task automatic check_slot(input logic [8:0] x, input int h, input int k, input logic exp_done);
      int         cnt;
      logic [8:0] exp_addr;
      logic       exp_we;
      step();
      cnt = 0;
      for (int j = 0; j < k; j++) if (kept(h, j)) cnt++;
      exp_addr = x + 9'(cnt);
      exp_we   = kept(h, k);
`ifdef LB_CLIP_EN
      if (exp_addr >= 9'd320) exp_we = 1'b0;
`endif
      chk($sformatf("pix[%0d]", k), {28'b0, pix_idx}, k);
      chk($sformatf("we[%0d]", k), {31'b0, lb_we}, {31'b0, exp_we});
      chk($sformatf("addr[%0d]", k), {23'b0, lb_addr}, {23'b0, exp_addr});
      chk($sformatf("done[%0d]", k), {31'b0, spr_done}, {31'b0, exp_done});
      if (lb_we) begin
         wr_cnt++;
         wr_max = lb_addr;
      end
   endtask

   task automatic run_sprite(input logic [8:0] x, input int h, input string tag);
      for (int k = 0; k < 16; k++) check_slot(x, h, k, 1'b0);
      step();
      chk({tag, "_done"}, {31'b0, spr_done}, 32'd1);
      chk({tag, "_done_we"}, {31'b0, lb_we}, 32'd0);
   endtask

   initial begin
      logic saw_we;
      logic saw_done;
      n_vec = 0;
      n_err = 0;
      rst_n = 1'b0;
      line_start = 1'b0;
      spr_load = 1'b0;
      pipe_c = '0;
      repeat (3) step();

      chk("rst_addr", {23'b0, lb_addr}, 0);
      chk("rst_we", {31'b0, lb_we}, 0);
      chk("rst_pix", {28'b0, pix_idx}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_done", {31'b0, spr_done}, 0);
      chk("rst_ovr", {31'b0, overrun}, 0);
      rst_n = 1'b1;
      step();

      // basic: X=10, full width -> 10..25, NEXT_X=26
      load(9'd10, 4'd15, 1'b0);
      chk("basic_busy", {31'b0, busy}, 1);
      run_sprite(9'd10, 15, "basic");
      step();
      chk("basic_done_pulse", {31'b0, spr_done}, 0);
      chk("basic_idle", {31'b0, busy}, 0);

      // chain, h=7: X field ignored, odd columns write 26..33, NEXT_X=34
      load(9'd200, 4'd7, 1'b1);
      run_sprite(9'd26, 7, "chain");
      load(9'd0, 4'd0, 1'b1);
      run_sprite(9'd34, 0, "chain2");
      step();

      // back-to-back: A accepted, B pending, C dropped
      set_load(9'd100, 4'd15, 1'b0);
      step();
      set_load(9'd150, 4'd15, 1'b0);
      check_slot(9'd100, 15, 0, 1'b0);
      set_load(9'd300, 4'd15, 1'b0);
      check_slot(9'd100, 15, 1, 1'b0);
      spr_load = 1'b0;
      chk("ovr_set", {31'b0, overrun}, 1);
      for (int k = 2; k < 16; k++) check_slot(9'd100, 15, k, 1'b0);
      check_slot(9'd150, 15, 0, 1'b1);
      for (int k = 1; k < 16; k++) check_slot(9'd150, 15, k, 1'b0);
      step();
      chk("b2b_done", {31'b0, spr_done}, 1);
      chk("ovr_sticky", {31'b0, overrun}, 1);
      // dropped load left NEXT_X at 166
      load(9'd0, 4'd15, 1'b1);
      run_sprite(9'd166, 15, "b2b_chain");
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      chk("ovr_clr", {31'b0, overrun}, 0);

      // wrap: 508..511, 0..11
      load(9'd508, 4'd15, 1'b0);
      run_sprite(9'd508, 15, "wrap");

      // clip: X=312
      wr_cnt = 0;
      wr_max = '0;
      load(9'd312, 4'd15, 1'b0);
      run_sprite(9'd312, 15, "clip");
`ifdef LB_CLIP_EN
      chk("clip_writes", wr_cnt, 8);
      chk("clip_max", {23'b0, wr_max}, 319);
`else
      chk("clip_writes", wr_cnt, 16);
      chk("clip_max", {23'b0, wr_max}, 327);
`endif
      step();

      // abort: LINE_START at slot 5 with pending valid
      set_load(9'd50, 4'd15, 1'b0);
      step();
      set_load(9'd80, 4'd3, 1'b0);
      check_slot(9'd50, 15, 0, 1'b0);
      spr_load = 1'b0;
      for (int k = 1; k < 6; k++) check_slot(9'd50, 15, k, 1'b0);
      line_start = 1'b1;
      step();
      line_start = 1'b0;
      chk("abort_we", {31'b0, lb_we}, 0);
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_done", {31'b0, spr_done}, 0);
      saw_we = 1'b0;
      saw_done = 1'b0;
      repeat (20) begin
         step();
         saw_we |= lb_we;
         saw_done |= spr_done;
      end
      chk("abort_quiet_we", {31'b0, saw_we}, 0);
      chk("abort_quiet_done", {31'b0, saw_done}, 0);
      load(9'd77, 4'd4, 1'b1);
      run_sprite(9'd0, 4, "abort_chain");
      step();

      // asynchronous reset mid-emission
      load(9'd10, 4'd15, 1'b0);
      repeat (4) step();
      chk("pre_rst_we", {31'b0, lb_we}, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_we", {31'b0, lb_we}, 0);
      chk("arst_addr", {23'b0, lb_addr}, 0);
      chk("arst_pix", {28'b0, pix_idx}, 0);
      chk("arst_busy", {31'b0, busy}, 0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_idle", {31'b0, busy}, 0);
      load(9'd5, 4'd15, 1'b1);
      run_sprite(9'd0, 15, "post_rst_chain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
